// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the radix-2 SDF FFT pipeline output stage.
//   bitrev()    : reverses the low 'nbits' bits of an index
//   cplx_t      : complex sample laid out as {real, img}, 2*FFT_W bits
//   rd_state_e  : read-side FSM states of fft_reorder_buf
// No ports (package).
// ---------------------------------------------------------------------------
package fft_pkg;

    // Default component width; cplx_t matches the default W of the reorder
    // buffer. Wider builds use plain 2*W vectors with the same {real, img}
    // layout.
    localparam int FFT_W = 16;

    typedef struct packed {
        logic signed [FFT_W-1:0] re;
        logic signed [FFT_W-1:0] im;
    } cplx_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RUN  = 1'b1
    } rd_state_e;

    // Shifts bits out of the LSB of 'val' and into the LSB of the result,
    // so after 'nbits' steps the low field is mirrored. Callers cast the
    // result down to their own index width.
    function automatic logic [31:0] bitrev(input logic [31:0] val,
                                           input int unsigned nbits);
        logic [31:0] v;
        logic [31:0] r;
        v = val;
        r = '0;
        for (int unsigned i = 0; i < nbits; i++) begin
            r = {r[30:0], v[0]};
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_mem.sv
// ---------------------------------------------------------------------------
// fft_reorder_mem
// Simple dual-port RAM backing both ping-pong banks of the reorder buffer.
// Address is {bank, index}; read data is registered.
//   clk      in   clock
//   rst_n    in   async active-low reset (clears the read data register only)
//   wr_en    in   write strobe
//   wr_addr  in   AW-bit write address
//   wr_data  in   DW-bit write data
//   rd_en    in   read strobe; read data register loads only when set
//   rd_addr  in   AW-bit read address
//   rd_data  out  DW-bit registered read data
// ---------------------------------------------------------------------------
module fft_reorder_mem
    import fft_pkg::*;
#(
    parameter int AW = 4,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rd_data_q;
    logic [DW-1:0] rd_data_d;

    // Storage array is never reset: stale contents are harmless because a
    // bank is only read after it has been completely refilled.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read data holds between reads so the output bus stays stable.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    // The read register doubles as the output data register of the
    // reorder buffer, so it must come out of reset at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fft_reorder_buf.sv
// ---------------------------------------------------------------------------
// fft_reorder_buf
// Converts the bit-reversed serial output of the last SDF butterfly stage
// into natural-order frames of 2^N samples using two ping-pong banks.
// Optional frame sync feature: define FFT_REORDER_SYNC_EN.
//   clk        in   clock, rising edge
//   rst_n      in   async active-low reset
//   in_valid   in   input sample present
//   in_real    in   W-bit signed real part
//   in_img     in   W-bit signed imaginary part
//   in_sof     in   start of frame (FFT_REORDER_SYNC_EN only)
//   out_valid  out  output sample present
//   out_real   out  W-bit real part
//   out_img    out  W-bit imaginary part
//   out_idx    out  N-bit natural frequency index
//   out_sof    out  high with index 0
//   sync_err   out  sticky misalignment flag (FFT_REORDER_SYNC_EN only)
// ---------------------------------------------------------------------------
module fft_reorder_buf
    import fft_pkg::*;
#(
    parameter int N = 3,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_real,
    input  logic [W-1:0] in_img,
`ifdef FFT_REORDER_SYNC_EN
    input  logic         in_sof,
    output logic         sync_err,
`endif
    output logic         out_valid,
    output logic [W-1:0] out_real,
    output logic [W-1:0] out_img,
    output logic [N-1:0] out_idx,
    output logic         out_sof
);

    localparam logic [N-1:0] LAST_IDX = '1;

    rd_state_e    rd_state_q, rd_state_d;
    logic [N-1:0] wr_cnt_q, wr_cnt_d;
    logic         wr_bank_q, wr_bank_d;
    logic         rd_pend_q, rd_pend_d;
    logic [N-1:0] rd_addr_q, rd_addr_d;
    logic         rd_bank_q, rd_bank_d;
    logic         out_valid_q, out_valid_d;
    logic [N-1:0] out_idx_q, out_idx_d;
    logic         out_sof_q, out_sof_d;
`ifdef FFT_REORDER_SYNC_EN
    logic         sync_err_q, sync_err_d;
`endif

    logic [N-1:0]   wr_idx;
    logic [N-1:0]   wr_rev;
    logic           frame_done;
    logic           rd_start;
    logic           rd_en;
    logic [2*W-1:0] rd_data;

    // Write side: each accepted sample lands at its bit-reversed position,
    // so the bank holds the frame in natural order once it is full. A
    // completed frame swaps banks and leaves a read request pending.
    always_comb begin
        wr_cnt_d   = wr_cnt_q;
        wr_bank_d  = wr_bank_q;
        wr_idx     = wr_cnt_q;
        frame_done = 1'b0;
`ifdef FFT_REORDER_SYNC_EN
        sync_err_d = sync_err_q;
`endif
        if (in_valid) begin
`ifdef FFT_REORDER_SYNC_EN
            if (in_sof) begin
                // Resync: restart the frame in the same bank; any partial
                // frame already written there is simply overwritten.
                wr_idx   = '0;
                wr_cnt_d = N'(1);
                if (wr_cnt_q != '0) begin
                    sync_err_d = 1'b1;
                end
            end else
`endif
            begin
                wr_cnt_d = wr_cnt_q + N'(1);
                if (wr_cnt_q == LAST_IDX) begin
                    wr_bank_d  = ~wr_bank_q;
                    frame_done = 1'b1;
                end
            end
        end
        wr_rev = N'(bitrev(32'(wr_idx), N));
    end

    // Read FSM: sweeps 0..2^N-1 of the filled bank without gaps and chains
    // straight into the next frame when one is already pending. The bank
    // being read is captured at frame start so that a bank swap landing
    // while the final address is still being read cannot redirect it.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_addr_d  = rd_addr_q;
        rd_bank_d  = rd_bank_q;
        rd_start   = 1'b0;
        rd_en      = (rd_state_q == RD_RUN);
        case (rd_state_q)
            RD_IDLE: begin
                if (rd_pend_q) begin
                    rd_state_d = RD_RUN;
                    rd_addr_d  = '0;
                    rd_bank_d  = ~wr_bank_q;
                    rd_start   = 1'b1;
                end
            end
            RD_RUN: begin
                rd_addr_d = rd_addr_q + N'(1);
                if (rd_addr_q == LAST_IDX) begin
                    if (rd_pend_q) begin
                        rd_bank_d = ~wr_bank_q;
                        rd_start  = 1'b1;
                    end else begin
                        rd_state_d = RD_IDLE;
                    end
                end
            end
            default: begin
                rd_state_d = RD_IDLE;
            end
        endcase

        // A new completion wins over a consume in the same cycle so that a
        // finished frame can never be lost.
        rd_pend_d = rd_pend_q;
        if (frame_done) begin
            rd_pend_d = 1'b1;
        end else if (rd_start) begin
            rd_pend_d = 1'b0;
        end

        // Sideband outputs align with the registered RAM read data.
        out_valid_d = rd_en;
        out_idx_d   = rd_en ? rd_addr_q : out_idx_q;
        out_sof_d   = rd_en && (rd_addr_q == '0);
    end

    // All control state and output flags; memory contents are untouched by
    // reset, which is what discards a partially written frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q  <= RD_IDLE;
            wr_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_addr_q   <= '0;
            rd_bank_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_sof_q   <= 1'b0;
`ifdef FFT_REORDER_SYNC_EN
            sync_err_q  <= 1'b0;
`endif
        end else begin
            rd_state_q  <= rd_state_d;
            wr_cnt_q    <= wr_cnt_d;
            wr_bank_q   <= wr_bank_d;
            rd_pend_q   <= rd_pend_d;
            rd_addr_q   <= rd_addr_d;
            rd_bank_q   <= rd_bank_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_sof_q   <= out_sof_d;
`ifdef FFT_REORDER_SYNC_EN
            sync_err_q  <= sync_err_d;
`endif
        end
    end

    fft_reorder_mem #(
        .AW (N + 1),
        .DW (2 * W)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (in_valid),
        .wr_addr ({wr_bank_q, wr_rev}),
        .wr_data ({in_real, in_img}),
        .rd_en   (rd_en),
        .rd_addr ({rd_bank_q, rd_addr_q}),
        .rd_data (rd_data)
    );

    assign out_valid = out_valid_q;
    assign out_real  = rd_data[2*W-1:W];
    assign out_img   = rd_data[W-1:0];
    assign out_idx   = out_idx_q;
    assign out_sof   = out_sof_q;
`ifdef FFT_REORDER_SYNC_EN
    assign sync_err  = sync_err_q;
`endif

endmodule

// File: tb/tb_fft_reorder_buf.sv
// ---------------------------------------------------------------------------
// tb_fft_reorder_buf
// Scoreboard bench for fft_reorder_buf (N=3, W=16). A frame model collects
// accepted samples in arrival order; when a frame completes it pushes the
// natural-order samples, each tagged with the clock edge after which it must
// appear. A monitor on the falling edge pops and compares.
// Sync tests are included when FFT_REORDER_SYNC_EN is defined.
// ---------------------------------------------------------------------------
module tb_fft_reorder_buf;

    localparam int N   = 3;
    localparam int W   = 16;
    localparam int LEN = 1 << N;
`ifdef FFT_REORDER_SYNC_EN
    localparam bit SYNC_ON = 1'b1;
`else
    localparam bit SYNC_ON = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] re;
        logic [W-1:0] im;
        int           idx;
        bit           sof;
        int           exp_edge;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_real = '0;
    logic [W-1:0] in_img = '0;
    logic         in_sof = 1'b0;
    logic         out_valid;
    logic [W-1:0] out_real;
    logic [W-1:0] out_img;
    logic [N-1:0] out_idx;
    logic         out_sof;
`ifdef FFT_REORDER_SYNC_EN
    logic         sync_err;
`endif

    int             edge_cnt = 0;
    int             tests = 0;
    int             fails = 0;
    bit             exp_sync_err = 1'b0;
    exp_t           sb[$];
    logic [2*W-1:0] arrival[$];

    fft_reorder_buf #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_real   (in_real),
        .in_img    (in_img),
`ifdef FFT_REORDER_SYNC_EN
        .in_sof    (in_sof),
        .sync_err  (sync_err),
`endif
        .out_valid (out_valid),
        .out_real  (out_real),
        .out_img   (out_img),
        .out_idx   (out_idx),
        .out_sof   (out_sof)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    // Bit reversal of an N-bit index by plain arithmetic.
    function automatic int rev(input int v);
        int r = 0;
        for (int b = 0; b < N; b++) r = r * 2 + ((v >> b) & 1);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at edge %0d",
                     name, act, exp, edge_cnt);
        end
    endtask

    // Drives one cycle of input and updates the frame model. The sample is
    // captured at the next rising edge (edge_cnt+1); natural index k of the
    // frame must appear after edge (capture edge + 2 + k).
    task automatic applyStimulus(input bit v, input logic [W-1:0] re,
                                 input logic [W-1:0] im, input bit sof);
        @(negedge clk);
        in_valid = v;
        in_real  = re;
        in_img   = im;
        in_sof   = sof;
        if (v) begin
            if (SYNC_ON && sof) begin
                if (arrival.size() != 0) exp_sync_err = 1'b1;
                arrival.delete();
            end
            arrival.push_back({re, im});
            if (arrival.size() == LEN) begin
                for (int k = 0; k < LEN; k++) begin
                    exp_t e;
                    logic [2*W-1:0] s;
                    s = arrival[rev(k)];
                    e.re = s[2*W-1:W];
                    e.im = s[W-1:0];
                    e.idx = k;
                    e.sof = (k == 0);
                    e.exp_edge = edge_cnt + 3 + k;
                    sb.push_back(e);
                end
                arrival.delete();
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0);
    endtask

    task automatic drain();
        int n = 0;
        idle(1);
        while (sb.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
        idle(2);
    endtask

    task automatic randomFrame(input int gap_pct);
        for (int i = 0; i < LEN; i++) begin
            while ($urandom_range(99) < gap_pct) applyStimulus(1'b0, W'($urandom), W'($urandom), 1'b0);
            applyStimulus(1'b1, W'($urandom), W'($urandom), 1'b0);
        end
    endtask

    // Monitor: every presented output must match the head of the
    // scoreboard, including the edge it appears on; an expected output
    // whose edge passes without out_valid is reported as missing.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("spurious_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("out_real", 32'(out_real), 32'(e.re));
                    checkOutput("out_img", 32'(out_img), 32'(e.im));
                    checkOutput("out_idx", 32'(out_idx), 32'(e.idx));
                    checkOutput("out_sof", 32'(out_sof), 32'(e.sof));
                    checkOutput("out_edge", 32'(edge_cnt), 32'(e.exp_edge));
                end
            end else if (sb.size() > 0 && sb[0].exp_edge <= edge_cnt) begin
                checkOutput("missing_output", 32'd0, 32'd1);
                void'(sb.pop_front());
            end
        end
    end

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_real"}, 32'(out_real), 32'd0);
        checkOutput({tag, "_img"}, 32'(out_img), 32'd0);
        checkOutput({tag, "_idx"}, 32'(out_idx), 32'd0);
        checkOutput({tag, "_sof"}, 32'(out_sof), 32'd0);
`ifdef FFT_REORDER_SYNC_EN
        checkOutput({tag, "_sync_err"}, 32'(sync_err), 32'd0);
`endif
    endtask

    initial begin
        int single_re[8];
        single_re = '{0, 4, 2, 6, 1, 5, 3, 7};

        // Reset state
        repeat (3) @(negedge clk);
        checkResetState("reset");
        rst_n = 1'b1;
        idle(2);
        checkResetState("post_reset");

        // Single frame 0,4,2,6,1,5,3,7 -> natural order 0..7
        for (int i = 0; i < LEN; i++)
            applyStimulus(1'b1, W'(single_re[i]), W'($urandom), 1'b0);
        drain();

        // Four back-to-back frames, no gaps
        for (int f = 0; f < 4; f++) randomFrame(0);
        drain();

        // in_valid toggling 1,0,1,0 through a frame
        for (int i = 0; i < LEN; i++) begin
            applyStimulus(1'b1, W'(single_re[i]), W'($urandom), 1'b0);
            applyStimulus(1'b0, W'($urandom), W'($urandom), 1'b0);
        end
        drain();

        // Reset after 5 samples, then a fresh frame
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, W'($urandom), W'($urandom), 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        arrival.delete();
        exp_sync_err = 1'b0;
        #1;
        checkResetState("midframe_reset");
        @(negedge clk);
        rst_n = 1'b1;
        randomFrame(0);
        drain();

        // Negative full scale real, positive full scale imaginary
        for (int i = 0; i < LEN; i++)
            applyStimulus(1'b1, (i % 2 == 0) ? 16'h8000 : W'($urandom),
                          (i % 2 == 0) ? 16'h7FFF : 16'h8000, 1'b0);
        drain();

        // Random gaps, streamed
        for (int f = 0; f < 6; f++) randomFrame(30);
        drain();

`ifdef FFT_REORDER_SYNC_EN
        // Sync: in_sof at sample 3 drops the partial frame
        checkOutput("sync_err_before", 32'(sync_err), 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, W'($urandom), W'($urandom), 1'b0);
        applyStimulus(1'b1, W'($urandom), W'($urandom), 1'b1);
        for (int i = 1; i < LEN; i++) applyStimulus(1'b1, W'($urandom), W'($urandom), 1'b0);
        randomFrame(0);
        drain();
        checkOutput("sync_err_after", 32'(sync_err), 32'(exp_sync_err));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/fft_reorder_buf.md
# fft_reorder_buf

Output reorder stage of the radix-2 SDF FFT pipeline, directly downstream of the last `bf_stage`. It takes the serial complex stream, which arrives in bit-reversed index order, and re-emits each 2^N-point frame in natural order. It uses a ping-pong pair of 2^N-entry buffers so that frames can stream back-to-back with no stall.

## Interface
- `N`, default 3: log2 of the FFT length. A frame is 2^N samples.
- `W`, default 16: width of each signed fixed-point real/imaginary component.

- `clk`  in  1  pipeline clock; all logic is on the rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  input sample present this cycle
- `in_real`  in  W  input real part, signed
- `in_img`  in  W  input imaginary part, signed
- `in_sof`  in  1  start of frame; only present with `FFT_REORDER_SYNC_EN`
- `out_valid`  out  1  output sample present
- `out_real`  out  W  output real part
- `out_img`  out  W  output imaginary part
- `out_idx`  out  N  natural frequency index of the current output
- `out_sof`  out  1  high with output index 0
- `sync_err`  out  1  sticky frame-misalignment flag; only present with `FFT_REORDER_SYNC_EN`

## Operation
- Storage is two banks, each holding 2^N × 2W bits. `wr_bank` selects the bank being written. `rd_bank` is always `~wr_bank`.
- **Write side**
  - `wr_cnt` (N bits) advances only on cycles with `in_valid`. Gaps are allowed and simply hold the counter.
  - Each accepted sample goes to `mem[wr_bank][bitrev(wr_cnt)]`.
  - When `wr_cnt` wraps from 2^N−1 to 0, `wr_bank` toggles and `rd_pend` is set.
- **Read side** is a two-state FSM:
  - RD_IDLE → RD_RUN on `rd_pend`. `rd_pend` is cleared at the same edge.
  - RD_RUN reads addresses 0..2^N−1 of `rd_bank` on consecutive cycles. It never gaps.
  - After address 2^N−1, the FSM goes back to RD_IDLE. If `rd_pend` is set at that edge, it goes straight to RD_RUN instead, giving contiguous output.
- **No overflow:** readout takes exactly 2^N cycles and refilling a bank takes at least 2^N cycles. Therefore `rd_bank` is never overwritten while it is being read.
- **Simultaneous events:** a bank swap in the same cycle as the last read address is legal. The read of that address still uses the old bank.
- **Arithmetic:** none. Data is passed through bit-exact.
- **Reset** (asynchronous, any time, including mid-frame):
  - Clears `wr_cnt`, `wr_bank`, `rd_pend`, the FSM state, and all output registers.
  - Any partial frame is discarded. Memory contents are not cleared.
  - Outputs after reset: `out_valid`=0, `out_real`=0, `out_img`=0, `out_idx`=0, `out_sof`=0, `sync_err`=0.

## Timing
- The edge that captures the last sample of a frame is edge k.
  - The FSM enters RD_RUN at k+1, with read address 0 presented.
  - The output register loads at k+2, so `out_valid`, `out_sof` and `out_idx`=0 are visible after edge k+2.
- Frame latency is 2 cycles from the last input sample to the first output sample.
- `out_valid` stays high for exactly 2^N cycles per frame. `out_idx` increments by 1 each cycle.
- Under continuous input, `out_valid` stays high continuously from the first frame onward.

## Configuration
- `FFT_REORDER_SYNC_EN` defined:
  - Adds the `in_sof` and `sync_err` ports.
  - `in_sof` with `in_valid` forces that sample to write address `bitrev(0)` and sets `wr_cnt` to 1.
  - If `wr_cnt` was not 0 at that point, the partial frame is dropped without a bank swap and `sync_err` is set. It stays set until reset.
- `FFT_REORDER_SYNC_EN` undefined: frames are delimited purely by counting accepted samples from reset.

## Structure
- Shared package `fft_pkg` holds:
  - the `bitrev` function, parameterised by N;
  - the complex sample typedef `{real, img}` of 2W bits;
  - read FSM state enum.
- Sub-module `fft_reorder_mem`: simple dual-port RAM with 2^(N+1) entries × 2W bits, registered read, `{bank, addr}` addressing.
- The top level holds the counters, the FSM and the output registers.

## Test plan
- **Single frame, N=3:** feed real values 0,4,2,6,1,5,3,7 with in_valid continuous → outputs real 0..7 in order, `out_idx` 0..7, `out_sof` only on the first, first `out_valid` 2 edges after the last input.
- **Back-to-back frames:** 4 frames streamed continuously → `out_valid` is unbroken for 32 cycles, and each frame is in natural order.
- **Input gaps:** `in_valid` toggling 1,0,1,0 through a frame → same output values, with the output start referenced to the last accepted sample.
- **Reset mid-frame:** assert `rst_n`=0 after 5 samples → all outputs 0 immediately. A fresh 8-sample frame after reset → correct natural-order output, with no residue from the old frame.
- **Sync (macro on):** `in_sof` asserted at sample 3 of a frame → `sync_err`=1, the partial frame is never output, and the next complete frame is output correctly.
- **Negative full-scale values:** real −32768 and img 32767 with W=16 → passed through bit-exact.
